// File: rtl/logic_unit_arbiter_if.sv
// Handshake bundle between the four logic-unit requesters and the shared
// arbiter: request/opcode/operand fan-in plus grant and tagged result.
interface logic_unit_arbiter_if #(
  parameter int WIDTH = 1
);
  logic [3:0]         req;
  logic [7:0]         op;
  logic [4*WIDTH-1:0] a;
  logic [4*WIDTH-1:0] b;
  logic [3:0]         gnt;
  logic [WIDTH-1:0]   result;
  logic               result_valid;
  logic [1:0]         result_id;

  modport master (
    output req, op, a, b,
    input  gnt, result, result_valid, result_id
  );

  modport slave (
    input  req, op, a, b,
    output gnt, result, result_valid, result_id
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Shares one registered two-input logic unit (AND/OR/XOR/NOR) among four
// requesters. One operation every three cycles: sample/grant, compute, done.
// Optional macro LU_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it requester 0 has the highest fixed priority.
//
// state | meaning
// IDLE  | sampling req; winner's opcode/operands latched and gnt raised
// GRANT | gnt dropped; result computed, result_valid pulsed with result_id
// DONE  | result_valid dropped; round-robin pointer advanced past winner
module logic_unit_arbiter #(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  logic_unit_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_nxt;
  logic [1:0]       win_q, win_nxt;
  logic [1:0]       op_q, op_nxt;
  logic [WIDTH-1:0] a_q, a_nxt;
  logic [WIDTH-1:0] b_q, b_nxt;
  logic [3:0]       gnt_q, gnt_nxt;
  logic [WIDTH-1:0] res_q, res_nxt;
  logic             valid_q, valid_nxt;
  logic [1:0]       id_q, id_nxt;

  logic [1:0]       op_arr [4];
  logic [WIDTH-1:0] a_arr  [4];
  logic [WIDTH-1:0] b_arr  [4];
  logic [1:0]       pick;

  function automatic logic [WIDTH-1:0] lu_eval(
    input logic [1:0]       f,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    case (f)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  // Unpack the per-requester opcode and operand fields.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      op_arr[i] = bus.op[2*i +: 2];
      a_arr[i]  = bus.a[i*WIDTH +: WIDTH];
      b_arr[i]  = bus.b[i*WIDTH +: WIDTH];
    end
  end

`ifdef LU_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_nxt;
  logic [1:0] rr_cand;
  logic       rr_hit;

  // Round-robin search: ptr, ptr+1, ... wrapping; first set req wins.
  always_comb begin
    pick    = ptr_q;
    rr_hit  = 1'b0;
    rr_cand = ptr_q;
    for (int k = 0; k < 4; k++) begin
      rr_cand = ptr_q + 2'(k);
      if (!rr_hit && bus.req[rr_cand]) begin
        pick   = rr_cand;
        rr_hit = 1'b1;
      end
    end
  end
`else
  // Fixed priority: lowest requester index wins.
  always_comb begin
    pick = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[k]) pick = 2'(k);
    end
  end
`endif

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_nxt = state_q;
    win_nxt   = win_q;
    op_nxt    = op_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    gnt_nxt   = gnt_q;
    res_nxt   = res_q;
    valid_nxt = valid_q;
    id_nxt    = id_q;
`ifdef LU_ARB_ROUND_ROBIN_EN
    ptr_nxt   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          win_nxt   = pick;
          op_nxt    = op_arr[pick];
          a_nxt     = a_arr[pick];
          b_nxt     = b_arr[pick];
          gnt_nxt   = 4'b0001 << pick;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        gnt_nxt   = 4'b0000;
        res_nxt   = lu_eval(op_q, a_q, b_q);
        valid_nxt = 1'b1;
        id_nxt    = win_q;
        state_nxt = DONE;
      end
      DONE: begin
        valid_nxt = 1'b0;
`ifdef LU_ARB_ROUND_ROBIN_EN
        ptr_nxt   = win_q + 2'd1;
`endif
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = 4'b0000;
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gnt_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
`ifdef LU_ARB_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      win_q   <= win_nxt;
      op_q    <= op_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      gnt_q   <= gnt_nxt;
      res_q   <= res_nxt;
      valid_q <= valid_nxt;
      id_q    <= id_nxt;
`ifdef LU_ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_nxt;
`endif
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.result       = res_q;
  assign bus.result_valid = valid_q;
  assign bus.result_id    = id_q;

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one registered two-input logic unit (AND/OR/XOR/NOR) among four requesters. Each requester raises a request with an opcode and two operands. The arbiter picks one requester, grants it for one cycle, captures its operands and returns a registered result tagged with the requester index. It sits between the lab's gate-level test drivers and a single shared logic datapath.

## Interface
- WIDTH, 1, operand and result width in bits
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  4  request per requester, bit i = requester i
- op  in  8  opcode, requester i in bits [2i+1:2i]; 00 AND, 01 OR, 10 XOR, 11 NOR
- a  in  4*WIDTH  operand A, requester i in bits [WIDTH*(i+1)-1 : WIDTH*i]
- b  in  4*WIDTH  operand B, same packing as a
- gnt  out  4  one-hot grant, registered
- result  out  WIDTH  registered result of the granted operation
- result_valid  out  1  one-cycle pulse, result and result_id valid
- result_id  out  2  index of the requester that owns result

## Operation
- FSM states: IDLE, GRANT, DONE.
- IDLE
  - If req is nonzero at the clock edge: pick winner w; latch w, op[w], a[w] and b[w]; set gnt[w]; go to GRANT.
  - Otherwise stay in IDLE.
- GRANT
  - Clear gnt.
  - Load result = f(op_q, a_q, b_q), bitwise across all WIDTH bits.
  - Set result_valid, set result_id = w.
  - Go to DONE.
- DONE
  - Clear result_valid.
  - Update the round-robin pointer to (w+1) mod 4.
  - Go to IDLE.
  - result and result_id hold their values until the next load.
- Arbitration: round-robin starting from the pointer, searching ptr, ptr+1, ... mod 4; the first set req bit wins.
- Requests are sampled only in IDLE. req changes during GRANT or DONE are ignored until the FSM is back in IDLE.
- A requester must hold req, op, a and b stable until it sees its gnt bit. It should drop req in the cycle after gnt; otherwise it competes again in the next IDLE.
- A req bit that drops before being sampled in IDLE is never served. No state is retained for it.
- Reset values: state IDLE, gnt 0, result 0, result_valid 0, result_id 0, pointer 0, internal latches 0.
- Reset asserted in any state returns the FSM to IDLE at that edge. There is no result_valid pulse for an aborted operation.

## Timing
- Request sampled at edge N → gnt high from edge N to edge N+1.
- result_valid high from edge N+1 to edge N+2.
- The FSM is back in IDLE after edge N+2, so the next sample is at edge N+3.
- Sustained throughput: one operation per 3 cycles. Request-to-result latency is 2 cycles.
- gnt and result_valid are never high in the same cycle. At most one gnt bit is high at a time.
- result_valid is exactly one cycle wide.

## Configuration
- LU_ARB_ROUND_ROBIN_EN
  - Defined: round-robin arbitration, with the pointer updated in DONE as described above.
  - Undefined: fixed priority, where the lowest index wins (req[0] highest). The pointer register is removed and the DONE state performs no pointer update. All other timing is identical.

## Test plan
- Single request: req=0010, op[3:2]=01, a[1]=0, b[1]=1 → gnt=0010 one cycle after the sample edge; next cycle result=1, result_id=1, result_valid=1 for one cycle.
- Contention with the macro defined: req=1111 held continuously from reset → grants in order 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart.
- Truth table through requester 2 with op=01 (OR), (a,b) = 00, 01, 10, 11 → results 0, 1, 1, 1. Repeat with op 00, 10, 11 → AND, XOR and NOR results.
- Reset mid-operation: assert rst during GRANT → the next cycle shows gnt=0, result_valid=0, result=0, state IDLE; no valid pulse follows.
- Macro undefined: req[0] and req[3] held high → requester 0 is granted every 3 cycles and requester 3 is never granted.
- Request withdrawn: req[2] pulses high for one cycle while the FSM is in DONE → no grant and no result for requester 2.
